// File: rtl/down_counter_timer.sv
// Programmable down-counting timer with prescaler, one-shot/auto-reload
// modes and a registered one-cycle terminal-count pulse.
module down_counter_timer #(
  parameter int WIDTH = 16,
  parameter int PS_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PS_W-1:0]  prescale,
  input  logic             auto_reload,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             expired
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PS_W-1:0]  PS_ONE  = {{(PS_W-1){1'b0}}, 1'b1};

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic [PS_W-1:0]  ps_cnt, ps_cnt_nxt;
  logic [WIDTH-1:0] reload_reg, reload_nxt;
  logic [PS_W-1:0]  ps_reg, ps_reg_nxt;
  logic             ar_reg, ar_nxt;
  logic             tick;

  // A tick happens only while running, enabled, and the prescaler wraps.
  assign tick = (state == ST_RUN) && en && (ps_cnt == ps_reg);

  // Status flags come straight from the state register, so no input reaches them combinationally.
  assign busy    = (state == ST_RUN);
  assign expired = (state == ST_EXPIRED);

  // Next-state logic: stop beats load, load beats a tick; tc defaults low so it only lasts one cycle.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    tc_nxt     = 1'b0;
    ps_cnt_nxt = ps_cnt;
    reload_nxt = reload_reg;
    ps_reg_nxt = ps_reg;
    ar_nxt     = ar_reg;
    if (stop) begin
      state_nxt  = ST_IDLE;
      ps_cnt_nxt = '0;
    end else if (load) begin
      count_nxt  = load_val;
      reload_nxt = load_val;
      ps_reg_nxt = prescale;
      ar_nxt     = auto_reload;
      ps_cnt_nxt = '0;
      state_nxt  = ST_RUN;
    end else if ((state == ST_RUN) && en) begin
      if (tick) begin
        ps_cnt_nxt = '0;
        if (count != '0) begin
          count_nxt = count - CNT_ONE;
        end else begin
          tc_nxt = 1'b1;
          if (ar_reg) begin
            count_nxt = reload_reg;
          end else begin
            state_nxt = ST_EXPIRED;
          end
        end
      end else begin
        ps_cnt_nxt = ps_cnt + PS_ONE;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      tc         <= 1'b0;
      ps_cnt     <= '0;
      reload_reg <= '0;
      ps_reg     <= '0;
      ar_reg     <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      tc         <= tc_nxt;
      ps_cnt     <= ps_cnt_nxt;
      reload_reg <= reload_nxt;
      ps_reg     <= ps_reg_nxt;
      ar_reg     <= ar_nxt;
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: an arithmetic reference model
// derives expected outputs from the number of enabled cycles since the last load.
module tb_down_counter_timer;

  localparam int WIDTH = 16;
  localparam int PS_W  = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [PS_W-1:0]  prescale;
  logic             auto_reload;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             expired;

  int vectors;
  int errors;

  // Reference model: a loaded timer is described by (N, P, ar) and t, the
  // number of enabled running edges since the load; everything else follows.
  bit     m_loaded;
  int     m_n;
  int     m_p;
  bit     m_ar;
  longint m_t;
  int     m_held;
  bit     m_tc;

  down_counter_timer #(.WIDTH(WIDTH), .PS_W(PS_W)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .prescale(prescale), .auto_reload(auto_reload), .stop(stop),
    .count(count), .tc(tc), .busy(busy), .expired(expired)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint m_ticks();
    return m_t / longint'(m_p + 1);
  endfunction

  function automatic bit m_expired();
    return m_loaded && !m_ar && (m_ticks() >= longint'(m_n) + 1);
  endfunction

  function automatic int m_count();
    longint k;
    if (!m_loaded) return m_held;
    k = m_ticks();
    if (m_ar) return m_n - int'(k % (longint'(m_n) + 1));
    if (k >= longint'(m_n)) return 0;
    return m_n - int'(k);
  endfunction

  function automatic logic [WIDTH+2:0] model_out();
    logic [WIDTH-1:0] c;
    c = m_count();
    return {c, m_tc, m_loaded && !m_expired(), m_expired()};
  endfunction

  task automatic model_reset();
    m_loaded = 0; m_n = 0; m_p = 0; m_ar = 0; m_t = 0; m_held = 0; m_tc = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    longint k;
    if (stop) begin
      m_held   = m_count();
      m_loaded = 0;
      m_tc     = 0;
    end else if (load) begin
      m_loaded = 1; m_n = int'(load_val); m_p = int'(prescale);
      m_ar = auto_reload; m_t = 0; m_tc = 0;
    end else if (m_loaded && en && !m_expired()) begin
      m_t++;
      k = m_ticks();
      m_tc = (m_t % longint'(m_p + 1) == 0) &&
             (m_ar ? (k % (longint'(m_n) + 1) == 0) : (k == longint'(m_n) + 1));
    end else begin
      m_tc = 0;
    end
  endtask

  // One clock edge on both DUT and model; returns 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_load(input int n, input int p, input bit ar);
    load = 1; load_val = n[WIDTH-1:0]; prescale = p[PS_W-1:0]; auto_reload = ar;
    step();
    load = 0;
  endtask

  task automatic test_reset();
    rst = 0; en = 1; load = 0; stop = 0; load_val = '0; prescale = '0; auto_reload = 0;
    model_reset();
    #12;
    vectors++;
    if ({count, tc, busy, expired} !== {16'h0000, 3'b000}) begin
      errors++;
      $display("[TB] FAIL reset_values: got %h/%b%b%b, expected 0000/000", count, tc, busy, expired);
    end
    @(negedge clk); rst = 1;
    for (int i = 0; i < 3; i++) begin
      step(); vectors++;
      if ({count, tc, busy, expired} !== model_out()) begin
        errors++;
        $display("[TB] FAIL idle_after_reset: got %h, expected %h", {count, tc, busy, expired}, model_out());
      end
    end
  endtask

  task automatic test_one_shot();
    int exp_cnt [4] = '{3, 2, 1, 0};
    en = 1;
    do_load(3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({count, busy, expired} !== {exp_cnt[i][WIDTH-1:0], 2'b10} || tc !== 1'b0) begin
        errors++;
        $display("[TB] FAIL one_shot_seq[%0d]: got cnt=%0d tc=%b busy=%b exp=%b, expected cnt=%0d running", i, count, tc, busy, expired, exp_cnt[i]);
      end
      if (i < 3) step();
    end
    for (int i = 0; i < 5; i++) begin
      step(); vectors++;
      if ({count, tc, busy, expired} !== model_out()) begin
        errors++;
        $display("[TB] FAIL one_shot_end cyc %0d: got %h, expected %h", i, {count, tc, busy, expired}, model_out());
      end
    end
  endtask

  task automatic test_auto_reload();
    en = 1;
    do_load(2, 0, 1);
    for (int i = 0; i < 12; i++) begin
      step(); vectors++;
      if ({count, tc, busy, expired} !== model_out()) begin
        errors++;
        $display("[TB] FAIL auto_reload cyc %0d: got %h, expected %h", i, {count, tc, busy, expired}, model_out());
      end
    end
  endtask

  task automatic test_prescale();
    en = 1;
    do_load(1, 3, 1);
    for (int i = 0; i < 40; i++) begin
      en = !(i >= 13 && i < 18);
      step(); vectors++;
      if ({count, tc, busy, expired} !== model_out()) begin
        errors++;
        $display("[TB] FAIL prescale cyc %0d: got %h, expected %h", i, {count, tc, busy, expired}, model_out());
      end
    end
    en = 1;
  endtask

  task automatic test_priority();
    en = 1;
    do_load(8, 0, 1);
    for (int i = 0; i < 4; i++) step();
    stop = 1; load = 1; load_val = 16'd99; prescale = 8'd0; auto_reload = 1;
    step();
    stop = 0; load = 0;
    vectors++;
    if ({count, tc, busy, expired} !== {16'd4, 3'b000}) begin
      errors++;
      $display("[TB] FAIL stop_beats_load: got %h, expected %h", {count, tc, busy, expired}, {16'd4, 3'b000});
    end
    for (int i = 0; i < 3; i++) begin
      step(); vectors++;
      if ({count, tc, busy, expired} !== model_out()) begin
        errors++;
        $display("[TB] FAIL idle_hold cyc %0d: got %h, expected %h", i, {count, tc, busy, expired}, model_out());
      end
    end
    do_load(8, 0, 1);
    for (int i = 0; i < 4; i++) step();
    do_load(10, 0, 1);
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if ({count, tc, busy, expired} !== model_out()) begin
        errors++;
        $display("[TB] FAIL reload_mid_run cyc %0d: got %h, expected %h", i, {count, tc, busy, expired}, model_out());
      end
      step();
    end
  endtask

  task automatic test_boundaries();
    en = 1;
    do_load(0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(); vectors++;
      if ({count, tc, busy, expired} !== model_out()) begin
        errors++;
        $display("[TB] FAIL zero_reload cyc %0d: got %h, expected %h", i, {count, tc, busy, expired}, model_out());
      end
    end
    do_load(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(); vectors++;
      if ({count, tc, busy, expired} !== model_out()) begin
        errors++;
        $display("[TB] FAIL zero_oneshot cyc %0d: got %h, expected %h", i, {count, tc, busy, expired}, model_out());
      end
    end
    do_load(16'hFFFF, 0, 0);
    for (int i = 0; i < 65540; i++) begin
      step(); vectors++;
      if ({count, tc, busy, expired} !== model_out()) begin
        errors++;
        $display("[TB] FAIL max_oneshot cyc %0d: got %h, expected %h", i, {count, tc, busy, expired}, model_out());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      stop        = ($urandom % 30) == 0;
      load        = ($urandom % 12) == 0;
      en          = ($urandom % 5) != 0;
      load_val    = (($urandom % 10) == 0) ? WIDTH'($urandom) : WIDTH'($urandom % 8);
      prescale    = PS_W'($urandom % 4);
      auto_reload = $urandom % 2;
      step(); vectors++;
      if ({count, tc, busy, expired} !== model_out()) begin
        errors++;
        $display("[TB] FAIL random cyc %0d: got %h, expected %h", i, {count, tc, busy, expired}, model_out());
      end
    end
    stop = 0; load = 0; en = 1;
  endtask

  task automatic test_async_reset();
    en = 1;
    do_load(50, 1, 1);
    for (int i = 0; i < 10; i++) step();
    @(negedge clk);
    rst = 0;
    #1;
    model_reset();
    vectors++;
    if ({count, tc, busy, expired} !== {16'h0000, 3'b000}) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h/%b%b%b, expected 0000/000", count, tc, busy, expired);
    end
    #2 rst = 1;
    for (int i = 0; i < 3; i++) begin
      step(); vectors++;
      if ({count, tc, busy, expired} !== model_out()) begin
        errors++;
        $display("[TB] FAIL post_reset_idle cyc %0d: got %h, expected %h", i, {count, tc, busy, expired}, model_out());
      end
    end
    do_load(2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(); vectors++;
      if ({count, tc, busy, expired} !== model_out()) begin
        errors++;
        $display("[TB] FAIL post_reset_load cyc %0d: got %h, expected %h", i, {count, tc, busy, expired}, model_out());
      end
    end
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_prescale();
    test_priority();
    test_boundaries();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
